// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, GF(2^8) and S-box helpers, round transforms and the decrypt FSM state type
package aes_pkg;
  localparam int AES_NB = 4;
  localparam int AES_NR = 10;
  // Entry 0 is padding so that the table can be indexed 1..10 directly.
  localparam logic [0:10][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef enum logic [1:0] {IDLE, KEY_EXP, READY, DEC} aes_state_e;
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i >= 4'd1 && i <= 4'd10) ? RCON[i] : 8'h00;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction
  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction
  // S-boxes are generated from the field inverse and affine map instead of a stored table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  // Byte i of a block sits at bits [127-8i -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b) ^
                                gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_inv_key_step.sv
// aes_inv_key_step: one AES-128 key-schedule round, forward (inv=0) or backward (inv=1), with the given rcon byte
module aes_inv_key_step
  import aes_pkg::*;
(
  input  logic         inv,
  input  logic [7:0]   rcon_in,
  input  logic [127:0] key_in,
  output logic [127:0] key_out
);
  logic [31:0] w0, w1, w2, w3, b1, b2, b3, f0, f1, f2, t;
  // Both directions share one SubWord: backward feeds the recovered w3 (w3^w2), forward feeds w3.
  always_comb begin
    {w0, w1, w2, w3} = key_in;
    b3 = w3 ^ w2;
    b2 = w2 ^ w1;
    b1 = w1 ^ w0;
    t = sub_word(rot_word(inv ? b3 : w3)) ^ {rcon_in, 24'h000000};
    f0 = w0 ^ t;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    key_out = inv ? {w0 ^ t, b1, b2, b3} : {f0, f1, f2, w3 ^ f2};
  end
endmodule

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 inverse cipher, one block per 11 cycles, key schedule run backward on the fly
// ports: key_valid_in/cipher_key/key_ready load a key; data_valid_in/cipher_text/data_ready accept a block;
//        data_valid_out pulses for one cycle when plain_text holds a new result
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int KEY_LEN       = 128,
  parameter int DATA_LEN      = 128,
  parameter int NUMS_OF_ROUND = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid_in,
  input  logic [KEY_LEN-1:0]  cipher_key,
  output logic                key_ready,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] cipher_text,
  output logic                data_ready,
  output logic                data_valid_out,
  output logic [DATA_LEN-1:0] plain_text
);
  localparam logic [3:0] LAST = 4'(NUMS_OF_ROUND);
  aes_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [KEY_LEN-1:0] k0_q, k0_d, k10_q, k10_d, key_q, key_d, step_key;
  logic [DATA_LEN-1:0] blk_q, blk_d, pt_q, pt_d, core;
  logic dv_q, dv_d, dec, key_acc, data_acc;
  logic [7:0] rc;
  assign dec = state_q == DEC;
  assign key_ready = state_q == IDLE || state_q == READY;
  assign data_ready = state_q == READY && !key_valid_in;
  assign key_acc = key_valid_in && key_ready;
  assign data_acc = data_valid_in && data_ready;
  // Forward round r uses Rcon[r]; backward step producing k_r uses Rcon[r+1].
  assign rc = rcon(dec ? cnt_q + 4'd1 : cnt_q);
  assign core = inv_sub_bytes(inv_shift_rows(blk_q));
  assign data_valid_out = dv_q;
  assign plain_text = pt_q;
  aes_inv_key_step u_step (
    .inv     (dec),
    .rcon_in (rc),
    .key_in  (key_q),
    .key_out (step_key)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    k0_d = k0_q;
    k10_d = k10_q;
    key_d = key_q;
    blk_d = blk_q;
    pt_d = pt_q;
    dv_d = 1'b0;
    if (key_acc) begin
      state_d = KEY_EXP;
      cnt_d = 4'd1;
      k0_d = cipher_key;
      key_d = cipher_key;
    end else if (data_acc) begin
      state_d = DEC;
      cnt_d = LAST - 4'd1;
      key_d = k10_q;
      blk_d = cipher_text ^ k10_q;
    end else if (state_q == KEY_EXP) begin
      key_d = step_key;
      state_d = cnt_q == LAST ? READY : KEY_EXP;
      k10_d = cnt_q == LAST ? step_key : k10_q;
      cnt_d = cnt_q == LAST ? 4'd0 : cnt_q + 4'd1;
    end else if (dec) begin
      key_d = step_key;
      state_d = cnt_q == 4'd0 ? READY : DEC;
      cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      blk_d = cnt_q == 4'd0 ? core ^ k0_q : inv_mix_columns(core ^ step_key);
      pt_d = cnt_q == 4'd0 ? core ^ k0_q : pt_q;
      dv_d = cnt_q == 4'd0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      k0_q <= '0;
      k10_q <= '0;
      key_q <= '0;
      blk_q <= '0;
      pt_q <= '0;
      dv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      k0_q <= k0_d;
      k10_q <= k10_d;
      key_q <= key_d;
      blk_q <= blk_d;
      pt_q <= pt_d;
      dv_q <= dv_d;
    end
  // The final backward step must land exactly on the stored round-0 key.
  assert property (@(posedge clk) disable iff (reset) (dec && cnt_q == 4'd0) |-> step_key == k0_q);
endmodule
